// File: rtl/vx_smem_rsp_merge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vx_smem_rsp_merge                                                |
// | Brief   : Merges bank-split shared-memory read partials into one response. |
// |           Optional perf counters: define SMEM_RSP_MERGE_PERF_EN.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vx_smem_rsp_merge #(
  parameter int NUM_REQS         = 4,
  parameter int WORD_SIZE        = 4,
  parameter int CORE_TAG_WIDTH   = 10,
  parameter int CORE_TAG_ID_BITS = 8,
  parameter int REQ_FIFO_SIZE    = 4
`ifdef SMEM_RSP_MERGE_PERF_EN
  , parameter int PERF_CTR_BITS  = 32
`endif
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_req_valid,
  input  logic [NUM_REQS-1:0]                i_req_tmask,
  input  logic [CORE_TAG_WIDTH-1:0]          i_req_tag,
  output logic                               o_req_ready,
  input  logic                               i_in_valid,
  input  logic [NUM_REQS-1:0]                i_in_tmask,
  input  logic [NUM_REQS*8*WORD_SIZE-1:0]    i_in_data,
  input  logic [CORE_TAG_WIDTH-1:0]          i_in_tag,
  output logic                               o_in_ready,
  output logic                               o_out_valid,
  output logic [NUM_REQS-1:0]                o_out_tmask,
  output logic [NUM_REQS*8*WORD_SIZE-1:0]    o_out_data,
  output logic [CORE_TAG_WIDTH-1:0]          o_out_tag,
  input  logic                               i_out_ready,
`ifdef SMEM_RSP_MERGE_PERF_EN
  output logic [PERF_CTR_BITS-1:0]           o_perf_partials,
  output logic [PERF_CTR_BITS-1:0]           o_perf_merges,
`endif
  output logic                               o_err
);

  localparam int c_WORD_W = 8 * WORD_SIZE;
  localparam int c_DATA_W = NUM_REQS * c_WORD_W;
  localparam int c_PTR_W  = $clog2(REQ_FIFO_SIZE);

  logic [NUM_REQS-1:0]       r_fifo_mask [REQ_FIFO_SIZE];
  logic [CORE_TAG_WIDTH-1:0] r_fifo_tag  [REQ_FIFO_SIZE];
  logic [c_PTR_W:0]          r_wptr, r_rptr;
  logic [NUM_REQS-1:0]       r_acc_mask;
  logic [c_DATA_W-1:0]       r_acc_data;
  logic                      r_out_valid;
  logic [NUM_REQS-1:0]       r_out_tmask;
  logic [c_DATA_W-1:0]       r_out_data;
  logic [CORE_TAG_WIDTH-1:0] r_out_tag;
  logic                      r_err;

  logic                      w_empty, w_full, w_push, w_in_ready, w_in_fire, w_done;
  logic                      w_proto_err;
  logic [NUM_REQS-1:0]       w_head_mask, w_mask_all;
  logic [CORE_TAG_WIDTH-1:0] w_head_tag;
  logic [c_DATA_W-1:0]       w_merged_data;
  logic                      w_unused_tag_hi;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                       (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);
  assign w_push      = i_req_valid && !w_full;
  assign w_head_mask = r_fifo_mask[r_rptr[c_PTR_W-1:0]];
  assign w_head_tag  = r_fifo_tag[r_rptr[c_PTR_W-1:0]];
  assign w_in_ready  = !w_empty && (!r_out_valid || i_out_ready);
  assign w_in_fire   = i_in_valid && w_in_ready;
  assign w_mask_all  = r_acc_mask | i_in_tmask;
  assign w_done      = w_in_fire && (w_mask_all == w_head_mask);

  assign w_proto_err = (i_in_tag[CORE_TAG_ID_BITS-1:0] != w_head_tag[CORE_TAG_ID_BITS-1:0])
                     || (|(i_in_tmask & r_acc_mask))
                     || (|(i_in_tmask & ~w_head_mask))
                     || (i_in_tmask == '0);

  // Upper tag bits are carried through but never compared.
  assign w_unused_tag_hi = ^i_in_tag[CORE_TAG_WIDTH-1:CORE_TAG_ID_BITS];

  always_comb begin
    w_merged_data = r_acc_data;
    for (int l = 0; l < NUM_REQS; l++) begin
      if (i_in_tmask[l] && w_head_mask[l]) begin
        w_merged_data[l*c_WORD_W +: c_WORD_W] = i_in_data[l*c_WORD_W +: c_WORD_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < REQ_FIFO_SIZE; i++) begin
        r_fifo_mask[i] <= '0;
        r_fifo_tag[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo_mask[r_wptr[c_PTR_W-1:0]] <= i_req_tmask;
        r_fifo_tag[r_wptr[c_PTR_W-1:0]]  <= i_req_tag;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_done) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_mask  <= '0;
      r_acc_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_tmask <= '0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_done) begin
        r_acc_mask  <= '0;
        r_acc_data  <= '0;
        r_out_valid <= 1'b1;
        r_out_tmask <= w_head_mask;
        r_out_data  <= w_merged_data;
        r_out_tag   <= w_head_tag;
      end else begin
        if (w_in_fire) begin
          r_acc_mask <= w_mask_all;
          r_acc_data <= w_merged_data;
        end
        if (r_out_valid && i_out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
      if (w_in_fire && w_proto_err) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef SMEM_RSP_MERGE_PERF_EN
  logic [PERF_CTR_BITS-1:0] r_perf_partials, r_perf_merges;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_partials <= '0;
      r_perf_merges   <= '0;
    end else begin
      if (w_in_fire) begin
        r_perf_partials <= r_perf_partials + 1'b1;
      end
      // A non-empty accumulator at completion means earlier partials existed.
      if (w_done && (r_acc_mask != '0)) begin
        r_perf_merges <= r_perf_merges + 1'b1;
      end
    end
  end

  assign o_perf_partials = r_perf_partials;
  assign o_perf_merges   = r_perf_merges;
`endif

  assign o_req_ready = !w_full;
  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_tmask = r_out_tmask;
  assign o_out_data  = r_out_data;
  assign o_out_tag   = r_out_tag;
  assign o_err       = r_err;

endmodule
`default_nettype wire
